shift_scheduler: RTL

//  Synthesizable shift sequencer for the 6-speed automatic gearbox. Replaces the behavioural
//  per-gear accel timers and the decel timer with one prescaled dwell counter.

---
 rtl/shift_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/shift_scheduler.sv
// Shift sequencer for the 6-speed gearbox: prescaled dwell timing,
// req/ack shift handshake, speedometer and one-hot timer LEDs.
module shift_scheduler #(
    parameter int TICK_DIV    = 50,
    parameter int DECEL_TICKS = 3,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       accel,
    input  logic       decel,
    input  logic       race,
    input  logic [2:0] gear,
    input  logic       shift_ack,
    output logic       shift_up,
    output logic       shift_dn,
    output logic [3:0] speed,
    output logic [4:0] timer_led,
    output logic       timeout,
    output logic       gear_err
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(ACK_TIMEOUT);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] AMAX = AW'(ACK_TIMEOUT - 1);
    localparam logic [3:0]    DMAX = 4'(DECEL_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEL,
        S_TOP,
        S_DECEL,
        S_UP_REQ,
        S_DN_REQ
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    dcnt_q, dcnt_d;
    logic [AW-1:0] ato_q, ato_d;
    logic [3:0]    speed_q, speed_d;
    logic [4:0]    led_q, led_d;
    logic          up_q, up_d;
    logic          dn_q, dn_d;
    logic          tout_q, tout_d;
    logic          gerr_q, gerr_d;

    logic       gear_bad;
    logic       counting;
    logic       tick;
    logic [3:0] spd_inc;
    logic [3:0] spd_dec;
    logic [3:0] dcnt_inc;
    logic [3:0] dwell;

    always_comb begin
        gear_bad = (gear == 3'd0) || (gear == 3'd7);
        counting = (state_q == S_ACCEL) || (state_q == S_TOP) ||
                   (state_q == S_DECEL);
        tick     = counting && (presc_q == PMAX);
        spd_inc  = (speed_q == 4'd15) ? speed_q : speed_q + 4'd1;
        spd_dec  = (speed_q == 4'd0) ? speed_q : speed_q - 4'd1;
        dcnt_inc = dcnt_q + 4'd1;
        dwell    = race ? (({1'b0, gear} + 4'd3) >> 1) : ({1'b0, gear} + 4'd2);

        state_d = state_q;
        speed_d = speed_q;
        dcnt_d  = dcnt_q;
        ato_d   = '0;
        tout_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // decel always blocks accel, even in gear 1 where it cannot shift
                if (!gear_bad) begin
                    if (decel) begin
                        if (gear > 3'd1) state_d = S_DECEL;
                    end else if (accel) begin
                        state_d = (gear == 3'd6) ? S_TOP : S_ACCEL;
                    end
                end
            end
            S_ACCEL, S_TOP: begin
                if (gear_bad || (!accel && !decel) ||
                    (decel && gear == 3'd1)) begin
                    state_d = S_IDLE;
                end else if (decel) begin
                    state_d = S_DECEL;
                end else if (tick) begin
                    speed_d = spd_inc;
                    if (state_q == S_ACCEL && spd_inc >= dwell)
                        state_d = S_UP_REQ;
                end
            end
            S_DECEL: begin
                if (gear_bad || !decel || gear == 3'd1) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    speed_d = spd_dec;
                    dcnt_d  = dcnt_inc;
                    if (dcnt_inc == DMAX) state_d = S_DN_REQ;
                end
            end
            S_UP_REQ, S_DN_REQ: begin
                if (shift_ack) begin
                    state_d = S_IDLE;
                    speed_d = '0;
                end else if (ato_q == AMAX) begin
                    state_d = S_IDLE;
                    tout_d  = 1'b1;
                end else begin
                    ato_d = ato_q + AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != S_DECEL) dcnt_d = '0;

        // any state change restarts the prescaler
        if (counting && state_d == state_q)
            presc_d = tick ? '0 : presc_q + PW'(1);
        else
            presc_d = '0;

        led_d = '0;
        if (state_d == S_ACCEL || state_d == S_TOP) begin
            case (gear)
                3'd1:    led_d = 5'b00001;
                3'd2:    led_d = 5'b00010;
                3'd3:    led_d = 5'b00100;
                3'd4:    led_d = 5'b01000;
                3'd5:    led_d = 5'b10000;
                3'd6:    led_d = 5'b10000;
                default: led_d = '0;
            endcase
        end

        up_d   = (state_d == S_UP_REQ);
        dn_d   = (state_d == S_DN_REQ);
        gerr_d = gear_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            dcnt_q  <= '0;
            ato_q   <= '0;
            speed_q <= '0;
            led_q   <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            tout_q  <= 1'b0;
            gerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            dcnt_q  <= dcnt_d;
            ato_q   <= ato_d;
            speed_q <= speed_d;
            led_q   <= led_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            tout_q  <= tout_d;
            gerr_q  <= gerr_d;
        end
    end

    assign shift_up  = up_q;
    assign shift_dn  = dn_q;
    assign speed     = speed_q;
    assign timer_led = led_q;
    assign timeout   = tout_q;
    assign gear_err  = gerr_q;
endmodule
